vx_mem_switch_tracked: RTL and testbench

- Parametrised 1-to-N memory request switch with N-to-1 response arbitration, for fanning one core-side memory bus out to NUM_OUTPUTS banks or devices (shared memory, local scratchpads, MMIO).
- Output port is selected by a bit field of the request tag. That field is stripped on the way out and re-inserted on the response.
- Adds per-output outstanding-read tracking with a hard MAX_PENDING cap.
- Registered request and response stages, and round-robin response fairness.

---
 rtl/vx_mem_switch_tracked.sv | 230 +++++++++++++++++++++++
 tb/tb_vx_mem_switch_tracked.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_switch_tracked.sv
// rtl/vx_mem_switch_tracked.sv - 1-to-N tag-routed memory switch with per-port read tracking.
// Optional stall counters are compiled in with VX_MEM_SWITCH_PERF_EN.
module vx_mem_switch_tracked #(
    parameter int NUM_OUTPUTS = 2,
    parameter int DATA_SIZE   = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAG_WIDTH   = 8,
    parameter int TAG_SEL_IDX = 0,
    parameter int MAX_PENDING = 4,
    localparam int SELW = $clog2(NUM_OUTPUTS),
    localparam int TAGO = TAG_WIDTH - SELW,
    localparam int DW   = 8 * DATA_SIZE,
    localparam int CNTW = $clog2(MAX_PENDING + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_req_valid,
    output logic                              in_req_ready,
    input  logic                              in_req_rw,
    input  logic [ADDR_WIDTH-1:0]             in_req_addr,
    input  logic [DATA_SIZE-1:0]              in_req_byteen,
    input  logic [DW-1:0]                     in_req_data,
    input  logic [TAG_WIDTH-1:0]              in_req_tag,
    output logic                              in_rsp_valid,
    input  logic                              in_rsp_ready,
    output logic [DW-1:0]                     in_rsp_data,
    output logic [TAG_WIDTH-1:0]              in_rsp_tag,
    output logic [NUM_OUTPUTS-1:0]            out_req_valid,
    input  logic [NUM_OUTPUTS-1:0]            out_req_ready,
    output logic [NUM_OUTPUTS-1:0]            out_req_rw,
    output logic [NUM_OUTPUTS*ADDR_WIDTH-1:0] out_req_addr,
    output logic [NUM_OUTPUTS*DATA_SIZE-1:0]  out_req_byteen,
    output logic [NUM_OUTPUTS*DW-1:0]         out_req_data,
    output logic [NUM_OUTPUTS*TAGO-1:0]       out_req_tag,
    input  logic [NUM_OUTPUTS-1:0]            out_rsp_valid,
    output logic [NUM_OUTPUTS-1:0]            out_rsp_ready,
    input  logic [NUM_OUTPUTS*DW-1:0]         out_rsp_data,
    input  logic [NUM_OUTPUTS*TAGO-1:0]       out_rsp_tag,
    output logic [NUM_OUTPUTS*CNTW-1:0]       pending_cnt
`ifdef VX_MEM_SWITCH_PERF_EN
    ,
    output logic [31:0]                       perf_req_stalls,
    output logic [31:0]                       perf_cap_stalls,
    output logic [31:0]                       perf_rsp_stalls
`endif
);

    localparam int SELI = (SELW > 0) ? SELW : 1;

    function automatic logic [TAGO-1:0] strip_sel(input logic [TAG_WIDTH-1:0] t);
        logic [TAGO-1:0] r;
        r = '0;
        for (int i = 0; i < TAGO; i++) begin
            r[i] = (i < TAG_SEL_IDX) ? t[i] : t[i + SELW];
        end
        return r;
    endfunction

    function automatic logic [TAG_WIDTH-1:0] insert_sel(input logic [TAGO-1:0] t, input logic [SELI-1:0] s);
        logic [TAG_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < TAG_WIDTH; i++) begin
            if (i < TAG_SEL_IDX)
                r[i] = t[i];
            else if (i < TAG_SEL_IDX + SELW)
                r[i] = s[i - TAG_SEL_IDX];
            else
                r[i] = t[i - SELW];
        end
        return r;
    endfunction

    logic [SELI-1:0]        sel;
    logic [NUM_OUTPUTS-1:0] sel_hit;
    logic [NUM_OUTPUTS-1:0] cnt_full;
    logic [NUM_OUTPUTS-1:0] inc;
    logic [NUM_OUTPUTS-1:0] dec;
    logic [NUM_OUTPUTS-1:0] grant;
    logic                   sel_legal;
    logic                   tgt_busy;
    logic                   cap_block;
    logic                   req_fire;
    logic [TAGO-1:0]        req_tag_out;

    generate
        if (NUM_OUTPUTS > 1) begin : g_sel
            assign sel = in_req_tag[TAG_SEL_IDX +: SELW];
        end else begin : g_nosel
            assign sel = '0;
        end
    endgenerate

    always_comb begin
        sel_hit  = '0;
        cnt_full = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            sel_hit[k]  = (sel == SELI'(k));
            cnt_full[k] = (pending_cnt[k*CNTW +: CNTW] == CNTW'(MAX_PENDING));
        end
    end

    // An out-of-range select matches no port: it is acknowledged and dropped.
    assign sel_legal    = |sel_hit;
    assign tgt_busy     = |(sel_hit & out_req_valid & ~out_req_ready);
    assign cap_block    = !in_req_rw && |(sel_hit & cnt_full);
    assign in_req_ready = !sel_legal || (!tgt_busy && !cap_block);
    assign req_fire     = in_req_valid && in_req_ready && sel_legal;
    assign inc          = (req_fire && !in_req_rw) ? sel_hit : '0;
    assign dec          = out_rsp_valid & out_rsp_ready;
    assign req_tag_out  = strip_sel(in_req_tag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_req_valid  <= '0;
            out_req_rw     <= '0;
            out_req_addr   <= '0;
            out_req_byteen <= '0;
            out_req_data   <= '0;
            out_req_tag    <= '0;
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (req_fire && sel_hit[k]) begin
                    out_req_valid[k]                         <= 1'b1;
                    out_req_rw[k]                            <= in_req_rw;
                    out_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH] <= in_req_addr;
                    out_req_byteen[k*DATA_SIZE +: DATA_SIZE] <= in_req_byteen;
                    out_req_data[k*DW +: DW]                 <= in_req_data;
                    out_req_tag[k*TAGO +: TAGO]              <= req_tag_out;
                end else if (out_req_ready[k]) begin
                    out_req_valid[k] <= 1'b0;
                end
            end
        end
    end

    // The cap gate on in_req_ready keeps increments from ever passing MAX_PENDING.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (inc[k] && !dec[k])
                    pending_cnt[k*CNTW +: CNTW] <= pending_cnt[k*CNTW +: CNTW] + CNTW'(1);
                else if (dec[k] && !inc[k] && pending_cnt[k*CNTW +: CNTW] != '0)
                    pending_cnt[k*CNTW +: CNTW] <= pending_cnt[k*CNTW +: CNTW] - CNTW'(1);
            end
        end
    end

    logic [SELI-1:0] rr_ptr;
    logic [SELI-1:0] next_ptr;
    logic [SELI-1:0] win_sel;
    logic [DW-1:0]   win_data;
    logic [TAGO-1:0] win_tag;
    logic            any_rsp;
    logic            can_take;
    logic            rsp_fire;
    int              arb_idx;

    // Search starts at rr_ptr so the last winner has lowest priority next time.
    always_comb begin
        grant    = '0;
        any_rsp  = 1'b0;
        win_sel  = '0;
        win_data = '0;
        win_tag  = '0;
        next_ptr = rr_ptr;
        arb_idx  = 0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            arb_idx = (int'(rr_ptr) + o) % NUM_OUTPUTS;
            if (!any_rsp && out_rsp_valid[arb_idx]) begin
                any_rsp          = 1'b1;
                grant[arb_idx]   = 1'b1;
                win_sel          = SELI'(arb_idx);
                next_ptr         = SELI'((arb_idx + 1) % NUM_OUTPUTS);
                win_data         = out_rsp_data[arb_idx*DW +: DW];
                win_tag          = out_rsp_tag[arb_idx*TAGO +: TAGO];
            end
        end
    end

    assign can_take      = !in_rsp_valid || in_rsp_ready;
    assign out_rsp_ready = can_take ? grant : '0;
    assign rsp_fire      = any_rsp && can_take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_rsp_valid <= 1'b0;
            in_rsp_data  <= '0;
            in_rsp_tag   <= '0;
            rr_ptr       <= '0;
        end else if (rsp_fire) begin
            in_rsp_valid <= 1'b1;
            in_rsp_data  <= win_data;
            in_rsp_tag   <= insert_sel(win_tag, win_sel);
            rr_ptr       <= next_ptr;
        end else if (in_rsp_ready) begin
            in_rsp_valid <= 1'b0;
        end
    end

`ifdef VX_MEM_SWITCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_req_stalls <= '0;
            perf_cap_stalls <= '0;
            perf_rsp_stalls <= '0;
        end else begin
            if (in_req_valid && !in_req_ready)
                perf_req_stalls <= perf_req_stalls + 32'd1;
            if (in_req_valid && !in_req_ready && cap_block)
                perf_cap_stalls <= perf_cap_stalls + 32'd1;
            if (in_rsp_valid && !in_rsp_ready)
                perf_rsp_stalls <= perf_rsp_stalls + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && in_req_valid)
            assert (sel_legal);
        if (reset)
            for (int k = 0; k < NUM_OUTPUTS; k++)
                if (dec[k])
                    assert (pending_cnt[k*CNTW +: CNTW] != '0);
    end
`endif

endmodule

// File: tb/tb_vx_mem_switch_tracked.sv
// tb/tb_vx_mem_switch_tracked.sv - directed self-checking bench for vx_mem_switch_tracked (4 ports, cap 2).
module tb_vx_mem_switch_tracked;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int TW   = 8;
    localparam int TAGO = 6;
    localparam int DW   = 32;
    localparam int CNTW = 2;

    logic              clk;
    logic              rst_n;
    logic              in_req_valid, in_req_ready, in_req_rw;
    logic [AW-1:0]     in_req_addr;
    logic [3:0]        in_req_byteen;
    logic [DW-1:0]     in_req_data;
    logic [TW-1:0]     in_req_tag;
    logic              in_rsp_valid, in_rsp_ready;
    logic [DW-1:0]     in_rsp_data;
    logic [TW-1:0]     in_rsp_tag;
    logic [N-1:0]      out_req_valid, out_req_ready, out_req_rw;
    logic [N*AW-1:0]   out_req_addr;
    logic [N*4-1:0]    out_req_byteen;
    logic [N*DW-1:0]   out_req_data;
    logic [N*TAGO-1:0] out_req_tag;
    logic [N-1:0]      out_rsp_valid, out_rsp_ready;
    logic [N*DW-1:0]   out_rsp_data;
    logic [N*TAGO-1:0] out_rsp_tag;
    logic [N*CNTW-1:0] pending_cnt;
`ifdef VX_MEM_SWITCH_PERF_EN
    logic [31:0]       perf_req_stalls, perf_cap_stalls, perf_rsp_stalls;
`endif

    int total = 0;
    int bad   = 0;

    vx_mem_switch_tracked #(
        .NUM_OUTPUTS(N), .DATA_SIZE(4), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .TAG_SEL_IDX(0), .MAX_PENDING(2)
    ) dut (
        .clk(clk), .reset(rst_n),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
        .in_req_addr(in_req_addr), .in_req_byteen(in_req_byteen), .in_req_data(in_req_data),
        .in_req_tag(in_req_tag),
        .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready), .in_rsp_data(in_rsp_data),
        .in_rsp_tag(in_rsp_tag),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_rw(out_req_rw),
        .out_req_addr(out_req_addr), .out_req_byteen(out_req_byteen), .out_req_data(out_req_data),
        .out_req_tag(out_req_tag),
        .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready), .out_rsp_data(out_rsp_data),
        .out_rsp_tag(out_rsp_tag),
        .pending_cnt(pending_cnt)
`ifdef VX_MEM_SWITCH_PERF_EN
        ,
        .perf_req_stalls(perf_req_stalls), .perf_cap_stalls(perf_cap_stalls),
        .perf_rsp_stalls(perf_rsp_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        in_req_valid = 0; in_req_rw = 0; in_req_addr = '0; in_req_byteen = '0;
        in_req_data = '0; in_req_tag = '0; in_rsp_ready = 0; out_req_ready = '0;
        out_rsp_valid = '0; out_rsp_data = '0; out_rsp_tag = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        total++; if (out_req_valid !== 4'b0) begin bad++; $display("FAIL rst_out_req_valid got=%b exp=0000", out_req_valid); end
        total++; if (in_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_in_rsp_valid got=%b exp=0", in_rsp_valid); end
        total++; if (pending_cnt !== 8'h00) begin bad++; $display("FAIL rst_pending got=%h exp=00", pending_cnt); end
`ifdef VX_MEM_SWITCH_PERF_EN
        total++; if (perf_req_stalls !== 0 || perf_rsp_stalls !== 0 || perf_cap_stalls !== 0) begin
            bad++; $display("FAIL rst_perf got=%0d/%0d/%0d exp=0/0/0", perf_req_stalls, perf_cap_stalls, perf_rsp_stalls); end
`endif
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_route();
        do_reset();
        out_req_ready = 4'hF;
        @(negedge clk);
        in_req_valid = 1; in_req_rw = 0; in_req_addr = 32'h100; in_req_tag = 8'h0E; in_req_byteen = 4'hF;
        #1;
        total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL route_ready got=%b exp=1", in_req_ready); end
        @(negedge clk);
        in_req_valid = 0;
        total++; if (out_req_valid !== 4'b0100) begin bad++; $display("FAIL route_valid got=%b exp=0100", out_req_valid); end
        total++; if (out_req_tag[2*TAGO +: TAGO] !== 6'h03) begin bad++; $display("FAIL route_tag got=%h exp=03", out_req_tag[2*TAGO +: TAGO]); end
        total++; if (out_req_addr[2*AW +: AW] !== 32'h100) begin bad++; $display("FAIL route_addr got=%h exp=100", out_req_addr[2*AW +: AW]); end
        total++; if (pending_cnt[2*CNTW +: CNTW] !== 2'd1) begin bad++; $display("FAIL route_pending got=%0d exp=1", pending_cnt[2*CNTW +: CNTW]); end
        // write with select 1: upper tag bits shift down, no tracking
        in_req_valid = 1; in_req_rw = 1; in_req_tag = 8'hF5; in_req_addr = 32'h204;
        @(negedge clk);
        in_req_valid = 0; in_req_rw = 0;
        total++; if (out_req_valid !== 4'b0010) begin bad++; $display("FAIL route_wr_valid got=%b exp=0010", out_req_valid); end
        total++; if (out_req_tag[1*TAGO +: TAGO] !== 6'h3D || out_req_rw[1] !== 1'b1) begin
            bad++; $display("FAIL route_wr_tag got=%h/%b exp=3d/1", out_req_tag[1*TAGO +: TAGO], out_req_rw[1]); end
        total++; if (pending_cnt[1*CNTW +: CNTW] !== 2'd0) begin bad++; $display("FAIL route_wr_pending got=%0d exp=0", pending_cnt[1*CNTW +: CNTW]); end
        out_rsp_valid = 4'b0100; out_rsp_tag[2*TAGO +: TAGO] = 6'h03; out_rsp_data[2*DW +: DW] = 32'hCAFE0002; in_rsp_ready = 1;
        #1;
        total++; if (out_rsp_ready !== 4'b0100) begin bad++; $display("FAIL route_rsp_ready got=%b exp=0100", out_rsp_ready); end
        @(negedge clk);
        out_rsp_valid = '0;
        total++; if (in_rsp_valid !== 1'b1 || in_rsp_tag !== 8'h0E) begin bad++; $display("FAIL route_rsp_tag got=%b/%h exp=1/0e", in_rsp_valid, in_rsp_tag); end
        total++; if (in_rsp_data !== 32'hCAFE0002) begin bad++; $display("FAIL route_rsp_data got=%h exp=cafe0002", in_rsp_data); end
        total++; if (pending_cnt[2*CNTW +: CNTW] !== 2'd0) begin bad++; $display("FAIL route_rsp_pending got=%0d exp=0", pending_cnt[2*CNTW +: CNTW]); end
        @(negedge clk);
        total++; if (in_rsp_valid !== 1'b0) begin bad++; $display("FAIL route_rsp_drain got=%b exp=0", in_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        do_reset();
        out_req_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_req_valid = (i < 4); in_req_rw = 0; in_req_tag = 8'(i); in_req_addr = 32'(i * 16);
            #1;
            if (i < 4) begin
                total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_req_ready); end
            end
            if (i > 0) begin
                exp_v = 4'b0001 << (i - 1);
                total++; if (out_req_valid !== exp_v) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, out_req_valid, exp_v); end
            end
        end
        in_req_valid = 0;
        total++; if (pending_cnt !== 8'h55) begin bad++; $display("FAIL b2b_pending got=%h exp=55", pending_cnt); end
    endtask

    task automatic test_cap();
        do_reset();
        out_req_ready = 4'hF;
        @(negedge clk);
        in_req_valid = 1; in_req_rw = 0; in_req_tag = 8'h01; in_req_addr = 32'h10;
        #1;
        total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL cap_first got=%b exp=1", in_req_ready); end
        @(negedge clk);
        total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL cap_second got=%b exp=1", in_req_ready); end
        @(negedge clk);
        total++; if (in_req_ready !== 1'b0) begin bad++; $display("FAIL cap_third got=%b exp=0", in_req_ready); end
        total++; if (pending_cnt[1*CNTW +: CNTW] !== 2'd2) begin bad++; $display("FAIL cap_full_cnt got=%0d exp=2", pending_cnt[1*CNTW +: CNTW]); end
        in_req_rw = 1;
        #1;
        total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL cap_write_bypass got=%b exp=1", in_req_ready); end
        in_req_rw = 0;
        @(negedge clk);
        out_rsp_valid = 4'b0010; out_rsp_tag = '0; in_rsp_ready = 1;
        #1;
        total++; if (out_rsp_ready !== 4'b0010) begin bad++; $display("FAIL cap_rsp_grant got=%b exp=0010", out_rsp_ready); end
        @(negedge clk);
        out_rsp_valid = '0;
        #1;
        total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL cap_retry got=%b exp=1", in_req_ready); end
        @(negedge clk);
        in_req_valid = 0;
        total++; if (pending_cnt[1*CNTW +: CNTW] !== 2'd2) begin bad++; $display("FAIL cap_after_cnt got=%0d exp=2", pending_cnt[1*CNTW +: CNTW]); end
`ifdef VX_MEM_SWITCH_PERF_EN
        total++; if (perf_req_stalls !== 32'd2 || perf_cap_stalls !== 32'd2) begin
            bad++; $display("FAIL cap_perf got=%0d/%0d exp=2/2", perf_req_stalls, perf_cap_stalls); end
`endif
    endtask

    task automatic test_writes();
        int accepted;
        accepted = 0;
        do_reset();
        out_req_ready = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_req_valid = 1; in_req_rw = 1; in_req_tag = 8'h04; in_req_data = 32'(i);
            #1;
            if (in_req_ready) accepted++;
        end
        @(negedge clk);
        in_req_valid = 0; in_req_rw = 0;
        total++; if (accepted != 10) begin bad++; $display("FAIL wr_accepted got=%0d exp=10", accepted); end
        total++; if (pending_cnt[0 +: CNTW] !== 2'd0) begin bad++; $display("FAIL wr_pending got=%0d exp=0", pending_cnt[0 +: CNTW]); end
        total++; if (out_req_valid !== 4'b0001 || out_req_data[0 +: DW] !== 32'd9) begin
            bad++; $display("FAIL wr_last got=%b/%h exp=0001/9", out_req_valid, out_req_data[0 +: DW]); end
    endtask

    task automatic test_grant();
        logic [3:0] exp_g;
        do_reset();
        out_req_ready = 4'hF; in_rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_req_valid = 1; in_req_rw = 0; in_req_tag = 8'(i % 2);
        end
        @(negedge clk);
        total++; if (pending_cnt[3:0] !== 4'b1010) begin bad++; $display("FAIL grant_pre_cnt got=%b exp=1010", pending_cnt[3:0]); end
        out_rsp_data[0 +: DW] = 32'hA0A0A0A0; out_rsp_data[DW +: DW] = 32'hB1B1B1B1; out_rsp_tag = '0;
        for (int c = 0; c < 6; c++) begin
            out_rsp_valid = 4'b0011;
            in_req_valid = (c == 1 || c == 2); in_req_tag = (c == 1) ? 8'h00 : 8'h01;
            #1;
            exp_g = (c % 2 == 1) ? 4'b0010 : 4'b0001;
            total++; if (out_rsp_ready !== exp_g) begin bad++; $display("FAIL grant[%0d] got=%b exp=%b", c, out_rsp_ready, exp_g); end
            if (c == 1 || c == 2) begin
                total++; if (in_req_ready !== 1'b1) begin bad++; $display("FAIL grant_req[%0d] got=%b exp=1", c, in_req_ready); end
            end
            if (c > 0) begin
                total++; if (in_rsp_valid !== 1'b1 || in_rsp_tag !== 8'((c - 1) % 2)) begin
                    bad++; $display("FAIL grant_tag[%0d] got=%b/%h exp=1/%h", c, in_rsp_valid, in_rsp_tag, (c - 1) % 2); end
            end
            @(negedge clk);
        end
        out_rsp_valid = '0; in_req_valid = 0;
        #1;
        total++; if (in_rsp_tag !== 8'h01 || in_rsp_data !== 32'hB1B1B1B1) begin
            bad++; $display("FAIL grant_last got=%h/%h exp=01/b1b1b1b1", in_rsp_tag, in_rsp_data); end
        total++; if (pending_cnt !== 8'h00) begin bad++; $display("FAIL grant_post_cnt got=%h exp=00", pending_cnt); end
    endtask

    task automatic test_rsp_stall();
        do_reset();
        out_req_ready = 4'hF;
        @(negedge clk);
        in_req_valid = 1; in_req_rw = 0; in_req_tag = 8'h00;
        @(negedge clk);
        in_req_tag = 8'h01;
        @(negedge clk);
        in_req_valid = 0; in_rsp_ready = 0;
        out_rsp_valid = 4'b0001; out_rsp_data[0 +: DW] = 32'h11112222; out_rsp_tag[0 +: TAGO] = 6'h2A;
        #1;
        total++; if (out_rsp_ready !== 4'b0001) begin bad++; $display("FAIL stall_load got=%b exp=0001", out_rsp_ready); end
        @(negedge clk);
        out_rsp_valid = 4'b0010; out_rsp_data[DW +: DW] = 32'h33334444; out_rsp_tag[TAGO +: TAGO] = 6'h15;
        for (int s = 0; s < 5; s++) begin
            #1;
            total++; if (in_rsp_valid !== 1'b1 || in_rsp_data !== 32'h11112222 || in_rsp_tag !== 8'hA8) begin
                bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/11112222/a8", s, in_rsp_valid, in_rsp_data, in_rsp_tag); end
            total++; if (out_rsp_ready !== 4'b0000) begin bad++; $display("FAIL stall_no_ready[%0d] got=%b exp=0000", s, out_rsp_ready); end
            @(negedge clk);
        end
        in_rsp_ready = 1;
        #1;
`ifdef VX_MEM_SWITCH_PERF_EN
        total++; if (perf_rsp_stalls !== 32'd5) begin bad++; $display("FAIL stall_perf got=%0d exp=5", perf_rsp_stalls); end
`endif
        total++; if (out_rsp_ready !== 4'b0010) begin bad++; $display("FAIL stall_release got=%b exp=0010", out_rsp_ready); end
        @(negedge clk);
        out_rsp_valid = '0;
        #1;
        total++; if (in_rsp_tag !== 8'h55 || in_rsp_data !== 32'h33334444) begin
            bad++; $display("FAIL stall_next got=%h/%h exp=55/33334444", in_rsp_tag, in_rsp_data); end
        total++; if (pending_cnt !== 8'h00) begin bad++; $display("FAIL stall_cnt got=%h exp=00", pending_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_req_ready = 4'b1110;
        @(negedge clk);
        in_req_valid = 1; in_req_rw = 0; in_req_tag = 8'h01;
        @(negedge clk);
        in_req_tag = 8'h01;
        @(negedge clk);
        in_req_tag = 8'h04; in_req_addr = 32'h44;
        @(negedge clk);
        in_req_valid = 0;
        @(negedge clk);
        total++; if (out_req_valid !== 4'b0001 || out_req_addr[0 +: AW] !== 32'h44 || out_req_tag[0 +: TAGO] !== 6'h01) begin
            bad++; $display("FAIL mid_hold got=%b/%h/%h exp=0001/44/01", out_req_valid, out_req_addr[0 +: AW], out_req_tag[0 +: TAGO]); end
        total++; if (pending_cnt !== 8'h09) begin bad++; $display("FAIL mid_cnt got=%h exp=09", pending_cnt); end
        in_req_valid = 1; in_req_tag = 8'h00;
        #1;
        total++; if (in_req_ready !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", in_req_ready); end
        in_req_valid = 0;
        #1;
        rst_n = 0;
        #1;
        total++; if (out_req_valid !== 4'b0000 || pending_cnt !== 8'h00) begin
            bad++; $display("FAIL mid_async got=%b/%h exp=0000/00", out_req_valid, pending_cnt); end
        repeat (2) @(negedge clk);
        total++; if (out_req_valid !== 4'b0000 || in_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL mid_held got=%b/%b exp=0000/0", out_req_valid, in_rsp_valid); end
        rst_n = 1; out_req_ready = 4'hF;
        @(negedge clk);
        in_req_valid = 1; in_req_tag = 8'h03;
        @(negedge clk);
        in_req_valid = 0;
        total++; if (out_req_valid !== 4'b1000 || pending_cnt !== 8'h40) begin
            bad++; $display("FAIL mid_after got=%b/%h exp=1000/40", out_req_valid, pending_cnt); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_back_to_back();
        test_cap();
        test_writes();
        test_grant();
        test_rsp_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
